wishbone_sram_slave: RTL and testbench
======================================

Name: wishbone_sram_slave

Overview:
- Wishbone classic-cycle slave wrapping a word-organised on-chip SRAM with byte-lane writes.
- Sits on the SoC bus as the responder to the CPU-side Wishbone bus interface, for instruction or data memory.
- Inserts a configurable number of wait states.
- Returns a single-cycle registered ack per transfer.

Parameters:
- ADDR_WIDTH, 12: word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 2: extra cycles between request acceptance and ack; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wb_cyc_i  input  1  bus cycle valid.
- wb_stb_i  input  1  strobe; a request is cyc_i & stb_i.
- wb_we_i  input  1  1 = write, 0 = read.
- wb_sel_i  input  4  byte-lane select; bit n selects data[8n+7:8n].
- wb_addr_i  input  32  byte address; word index = addr[ADDR_WIDTH+1:2]; other bits ignored.
- wb_data_i  input  32  write data.
- wb_data_o  output  32  read data; valid only while wb_ack_o = 1, otherwise 32'h0.
- wb_ack_o  output  1  transfer acknowledge; one-cycle pulse.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, wait counter = 0, wb_ack_o = 0, wb_data_o = 0.
  - Latched request registers are cleared to 0.
  - SRAM contents are not cleared.
- States: IDLE, WAIT, ACK. Wait counter is 4 bits.
- IDLE:
  - On a clock edge with cyc_i & stb_i = 1, latch addr, we, sel and data.
  - If WAIT_STATES = 0, go to ACK; otherwise load counter with WAIT_STATES - 1 and go to WAIT.
  - With no request, stay in IDLE.
- WAIT:
  - If cyc_i = 0 or stb_i = 0 (master abort/flush): go to IDLE; no memory write, no ack.
  - Otherwise, if counter = 0, go to ACK; else decrement the counter.
  - Bus inputs changing during WAIT are ignored; the latched values are used.
- ACK (exactly one cycle):
  - wb_ack_o = 1, registered.
  - Read: wb_data_o = mem[latched index].
  - Write: on the edge entering ACK, write each byte lane of mem[latched index] where latched sel bit = 1; other lanes are unchanged. wb_data_o = 0.
  - Next state is IDLE unconditionally, even if cyc/stb are still high. The ack therefore never lasts more than one cycle.
- Latency:
  - wb_ack_o rises WAIT_STATES + 1 cycles after the edge at which the request was sampled.
  - Example: WAIT_STATES = 2 → request sampled at edge N, ack high during cycle N+3.
- Back-to-back transfers: at least one IDLE cycle between acks.
  - A request held high after ACK is re-accepted in IDLE as a new transfer.
  - This is correct behaviour, because the master drops stb on the edge that samples ack.
- Write with sel = 4'b0000: completes normally with ack; memory is unchanged.
- Address aliasing: bits above ADDR_WIDTH+1 are ignored, so addr 0x0000_0004 and 0x0000_4004 hit the same word when ADDR_WIDTH = 12. Bits [1:0] are also ignored.
- Reset asserted mid-transaction: the transfer is dropped immediately and the write does not occur. A write already performed on an earlier edge is retained.
- cyc_i = 1 with stb_i = 0 in IDLE: not a request; stay in IDLE.

Test Plan:
- Reset, then write 32'hDEADBEEF to addr 0x10 with sel = 4'hF, then read addr 0x10 (WAIT_STATES = 2) → ack exactly 3 cycles after each request sample; read wb_data_o = 32'hDEADBEEF during the ack cycle and 0 otherwise.
- Byte-lane write:
  - Write 32'h11223344 sel 4'hF to addr 0x20, then write 32'hAABBCCDD sel 4'b0101 to addr 0x20.
  - Read addr 0x20 → 32'h11BB33DD.
  - A further write with sel 4'b0000 → ack is returned and the word still reads 32'h11BB33DD.
- Abort: start a write of 32'hCAFEF00D to addr 0x30 (old value 0), drop stb after 1 cycle in WAIT → no ack ever; a subsequent read of 0x30 returns 0.
- Aliasing: write 32'h12345678 to 0x0000_4004, read 0x0000_0004 → 32'h12345678.
- Back-to-back: hold stb = 1 through two transfers → ack pulses are 1 cycle wide, separated by ≥1 low cycle; WAIT_STATES = 0 build gives ack on the cycle after sampling.
- Reset mid-WAIT: assert rst = 0 during WAIT of a write to 0x40 → wb_ack_o = 0 immediately (asynchronous), state IDLE; after release, a read of 0x40 returns the old value.

Source files
------------

// File: rtl/wishbone_sram_slave.sv
// Wishbone classic-cycle slave in front of a word-wide SRAM.
// Byte-lane writes, programmable wait states, one-cycle registered ack.
module wishbone_sram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LP_CNT =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_we;
  logic [3:0]            r_sel;
  logic [31:0]           r_wdat;
  logic [31:0]           r_rdat;
  logic [31:0]           r_mem [0:DEPTH-1];

  logic                  w_req;
  logic                  w_idle;
  logic                  w_enter_ack;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_we;
  logic [3:0]            w_sel;
  logic [31:0]           w_wdat;
  logic                  w_unused;

  assign w_req  = wb_cyc_i & wb_stb_i;
  assign w_idle = (r_state == S_IDLE);

  // With zero wait states the access happens on the accept edge,
  // before the request registers hold anything.
  assign w_idx  = w_idle ? wb_addr_i[ADDR_WIDTH+1:2] : r_idx;
  assign w_we   = w_idle ? wb_we_i   : r_we;
  assign w_sel  = w_idle ? wb_sel_i  : r_sel;
  assign w_wdat = w_idle ? wb_data_i : r_wdat;

  assign w_enter_ack = (w_next == S_ACK) && (r_state != S_ACK);

  assign w_unused = &{1'b0, wb_addr_i[31:ADDR_WIDTH+2],
                      wb_addr_i[1:0]};

  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            w_next = S_ACK;
          end else begin
            w_next = S_WAIT;
            w_cnt  = LP_CNT;
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_next = S_IDLE;
          w_cnt  = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_next = S_ACK;
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end
      S_ACK: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
        w_cnt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_sel   <= 4'd0;
      r_wdat  <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_idle && w_req) begin
        r_idx  <= wb_addr_i[ADDR_WIDTH+1:2];
        r_we   <= wb_we_i;
        r_sel  <= wb_sel_i;
        r_wdat <= wb_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enter_ack) begin
      if (w_we) begin
        for (int b = 0; b < 4; b++) begin
          if (w_sel[b]) begin
            r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
          end
        end
      end else begin
        r_rdat <= r_mem[w_idx];
      end
    end
  end

  assign wb_ack_o  = (r_state == S_ACK);
  assign wb_data_o = (wb_ack_o && !r_we) ? r_rdat : 32'd0;

endmodule

// File: tb/tb_wishbone_sram_slave.sv
// Directed self-checking bench for wishbone_sram_slave.
// Main instance uses 2 wait states, a second one uses 0.
module tb_wishbone_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        cyc0 = 1'b0;
  logic        stb0 = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdat = 32'd0;
  logic [31:0] rdat;
  logic [31:0] rdat0;
  logic        ack;
  logic        ack0;

  int checks = 0;
  int failures = 0;
  int bad_idle = 0;
  int ack_long = 0;

  logic [31:0] rd;
  int          lat;
  int          nack;
  logic [11:0] pat;

  always #5 clk = ~clk;

  wishbone_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_sel_i  (sel),
    .wb_addr_i (addr),
    .wb_data_i (wdat),
    .wb_data_o (rdat),
    .wb_ack_o  (ack)
  );

  wishbone_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .wb_cyc_i  (cyc0),
    .wb_stb_i  (stb0),
    .wb_we_i   (we),
    .wb_sel_i  (sel),
    .wb_addr_i (addr),
    .wb_data_i (wdat),
    .wb_data_o (rdat0),
    .wb_ack_o  (ack0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Scrambles the bus while waiting so that
  // only the latched request can produce the right result.
  task automatic xfer(input bit d0, input bit w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] r, output int l);
    logic a_now;
    logic [31:0] d_now;
    we = w; sel = s; addr = a; wdat = d;
    if (d0) begin cyc0 = 1'b1; stb0 = 1'b1; end
    else    begin cyc  = 1'b1; stb  = 1'b1; end
    l = 0;
    r = 32'hxxxxxxxx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      a_now = d0 ? ack0 : ack;
      d_now = d0 ? rdat0 : rdat;
      if (a_now === 1'b1) begin
        l = k;
        r = d_now;
        break;
      end
      if (d_now !== 32'd0) bad_idle++;
      we   = ~w;
      sel  = $urandom_range(15, 0);
      addr = $urandom;
      wdat = $urandom;
    end
    cyc = 1'b0; stb = 1'b0; cyc0 = 1'b0; stb0 = 1'b0;
    @(negedge clk);
    if (ack !== 1'b0 || ack0 !== 1'b0) ack_long++;
    if (rdat !== 32'd0 || rdat0 !== 32'd0) bad_idle++;
  endtask

  initial begin
    #2;
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_data", rdat, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    xfer(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, rd, lat);
    chk("wr10_lat", lat, 3);
    chk("wr10_data_zero", rd, 32'd0);
    xfer(0, 0, 4'hF, 32'h10, 32'h0, rd, lat);
    chk("rd10_lat", lat, 3);
    chk("rd10_data", rd, 32'hDEADBEEF);

    xfer(0, 1, 4'hF, 32'h20, 32'h11223344, rd, lat);
    xfer(0, 1, 4'h5, 32'h20, 32'hAABBCCDD, rd, lat);
    xfer(0, 0, 4'hF, 32'h20, 32'h0, rd, lat);
    chk("lanes_rd", rd, 32'h11BB33DD);
    xfer(0, 1, 4'h0, 32'h20, 32'hFFFFFFFF, rd, lat);
    chk("sel0_lat", lat, 3);
    xfer(0, 0, 4'hF, 32'h20, 32'h0, rd, lat);
    chk("sel0_rd", rd, 32'h11BB33DD);

    xfer(0, 1, 4'hF, 32'h30, 32'h0, rd, lat);
    we = 1'b1; sel = 4'hF; addr = 32'h30; wdat = 32'hCAFEF00D;
    cyc = 1'b1; stb = 1'b1;
    repeat (2) @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    nack = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack === 1'b1) nack++;
    end
    chk("abort_no_ack", nack, 0);
    xfer(0, 0, 4'hF, 32'h30, 32'h0, rd, lat);
    chk("abort_rd", rd, 32'h0);

    xfer(0, 1, 4'hF, 32'h4004, 32'h12345678, rd, lat);
    xfer(0, 0, 4'hF, 32'h0004, 32'h0, rd, lat);
    chk("alias_rd", rd, 32'h12345678);
    xfer(0, 0, 4'hF, 32'h0007, 32'h0, rd, lat);
    chk("alias_lsb_rd", rd, 32'h12345678);

    we = 1'b0; sel = 4'hF; addr = 32'h10;
    cyc = 1'b1; stb = 1'b1;
    pat = 12'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      pat[k] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_ws2_pat", {20'd0, pat}, 32'h444);
    repeat (4) @(negedge clk);

    xfer(1, 1, 4'hF, 32'h50, 32'h600DCAFE, rd, lat);
    chk("ws0_wr_lat", lat, 1);
    xfer(1, 0, 4'hF, 32'h50, 32'h0, rd, lat);
    chk("ws0_rd_lat", lat, 1);
    chk("ws0_rd_data", rd, 32'h600DCAFE);
    we = 1'b0; sel = 4'hF; addr = 32'h50;
    cyc0 = 1'b1; stb0 = 1'b1;
    pat = 12'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      pat[k] = ack0;
    end
    cyc0 = 1'b0; stb0 = 1'b0;
    chk("b2b_ws0_pat", {20'd0, pat}, 32'h555);
    @(negedge clk);

    xfer(0, 1, 4'hF, 32'h40, 32'h55AA55AA, rd, lat);
    we = 1'b1; sel = 4'hF; addr = 32'h40; wdat = 32'hFFFFFFFF;
    cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wait_ack", {31'd0, ack}, 32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    rst = 1'b1;
    nack = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack === 1'b1) nack++;
    end
    chk("rst_wait_no_ack", nack, 0);
    xfer(0, 0, 4'hF, 32'h40, 32'h0, rd, lat);
    chk("rst_wait_rd", rd, 32'h55AA55AA);

    we = 1'b1; sel = 4'hF; addr = 32'h44; wdat = 32'h0BADF00D;
    cyc = 1'b1; stb = 1'b1;
    nack = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ack === 1'b1) nack++;
    end
    chk("rst_ack_seen", nack, 1);
    rst = 1'b0;
    #1;
    chk("rst_ack_async", {31'd0, ack}, 32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    xfer(0, 0, 4'hF, 32'h44, 32'h0, rd, lat);
    chk("rst_ack_retained", rd, 32'h0BADF00D);

    chk("data_zero_no_ack", bad_idle, 0);
    chk("ack_one_cycle", ack_long, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
